// File: rtl/reset_tick_gen_pkg.sv
// rst_tick_pkg: shared FSM state type, loss counter width and counter width helper
package rst_tick_pkg;

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} rst_state_t;

    localparam int LOSS_CNT_W = 4;

    // Bits needed to hold 0..n-1, never less than one
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_tick_gen_divider.sv
// tick_divider: modulo-DIV counter that advances on adv and flags the wrapping step
module tick_divider
    import rst_tick_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output logic wrap
);

    localparam int W = cnt_w(DIV);
    localparam logic [W-1:0] MAX = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap = adv && (cnt_q == MAX);

    // Clear wins over advance; the wrapping step returns to zero
    always_comb cnt_d = (clr || wrap) ? '0 : adv ? cnt_q + W'(1) : cnt_q;

    // Counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/reset_tick_gen.sv
// reset_tick_gen: lock-qualified held-off reset, fast/slow tick enables and lock-loss counter
module reset_tick_gen
    import rst_tick_pkg::*;
#(
    parameter int CLK_HZ       = 10_000_000,
    parameter int HOLD_CYCLES  = 16,
    parameter int TICK_FAST_HZ = 1_000,
    parameter int TICK_SLOW_HZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked,
    output logic                  rst_out_n,
    output logic                  tick_fast,
    output logic                  tick_slow,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int FAST_DIV = CLK_HZ / TICK_FAST_HZ;
    localparam int SLOW_DIV = TICK_FAST_HZ / TICK_SLOW_HZ;
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (CLK_HZ % TICK_FAST_HZ != 0) begin : g_chk_fast_mod
        $error("CLK_HZ must be a multiple of TICK_FAST_HZ");
    end
    if (TICK_FAST_HZ % TICK_SLOW_HZ != 0) begin : g_chk_slow_mod
        $error("TICK_FAST_HZ must be a multiple of TICK_SLOW_HZ");
    end
    if (FAST_DIV < 2 || SLOW_DIV < 2) begin : g_chk_div
        $error("FAST_DIV and SLOW_DIV must both be at least 2");
    end

    logic [1:0]            sync_q;
    rst_state_t            state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  rst_out_q, tick_fast_q, tick_slow_q;
    logic                  locked_s, in_run, run_next, div_clr, fast_wrap, slow_wrap;

    assign locked_s      = sync_q[1];
    assign in_run        = (state_q == RUN);
    assign run_next      = (state_d == RUN);
    assign div_clr       = !in_run || !run_next;
    assign rst_out_n     = rst_out_q;
    assign tick_fast     = tick_fast_q;
    assign tick_slow     = tick_slow_q;
    assign lock_loss_cnt = loss_q;

    // Two-flop synchronizer for the asynchronous lock status
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], locked};

    // Next state, hold-off count and saturating loss count; only a loss from RUN counts
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        loss_d  = loss_q;
        case (state_q)
            WAIT_LOCK: begin
                hold_d = '0;
                if (locked_s) state_d = HOLD;
            end
            HOLD: begin
                hold_d = hold_q + HW'(1);
                if (!locked_s) state_d = WAIT_LOCK;
                else if (hold_q == HOLD_MAX) state_d = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    loss_d  = (loss_q == LOSS_MAX) ? loss_q : loss_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // State, counters and outputs decoded from the next state so they move together
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            hold_q      <= '0;
            loss_q      <= '0;
            rst_out_q   <= 1'b0;
            tick_fast_q <= 1'b0;
            tick_slow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            loss_q      <= loss_d;
            rst_out_q   <= run_next;
            tick_fast_q <= fast_wrap && run_next;
            tick_slow_q <= slow_wrap && run_next;
        end

    tick_divider #(.DIV(FAST_DIV)) u_fast (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (div_clr),
        .adv  (in_run),
        .wrap (fast_wrap)
    );

    tick_divider #(.DIV(SLOW_DIV)) u_slow (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (div_clr),
        .adv  (fast_wrap),
        .wrap (slow_wrap)
    );

endmodule

// File: tb/tb_reset_tick_gen.sv
// tb_reset_tick_gen: vector table plus scoreboarded sequences for reset release, ticks and lock loss
module tb_reset_tick_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b1;
    logic       rst_out_n, tick_fast, tick_slow;
    logic [3:0] lock_loss_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        string      nm;
        logic [6:0] v;
    } exp_t;

    typedef struct {
        logic       lk;
        logic [6:0] v;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    reset_tick_gen #(
        .CLK_HZ      (100),
        .HOLD_CYCLES (4),
        .TICK_FAST_HZ(10),
        .TICK_SLOW_HZ(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .rst_out_n    (rst_out_n),
        .tick_fast    (tick_fast),
        .tick_slow    (tick_slow),
        .lock_loss_cnt(lock_loss_cnt)
    );

    // Expected {rst_out_n, tick_fast, tick_slow} r edges after a clean lock edge 0
    function automatic logic [2:0] exp_run(input int r);
        return {r >= 6, r >= 16 && (r - 6) % 10 == 0, r >= 56 && (r - 6) % 50 == 0};
    endfunction

    task automatic pop_cmp();
        exp_t       e;
        logic [6:0] a;
        a = {rst_out_n, tick_fast, tick_slow, lock_loss_cnt};
        total_cnt++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got r=%b f=%b s=%b c=%0d, want a queued expectation",
                     a[6], a[5], a[4], a[3:0]);
        end else begin
            e = sb.pop_front();
            if (a !== e.v)
                $display("FAIL %s @%0t: got r=%b f=%b s=%b c=%0d, want r=%b f=%b s=%b c=%0d",
                         e.nm, $time, a[6], a[5], a[4], a[3:0], e.v[6], e.v[5], e.v[4], e.v[3:0]);
            else
                pass_cnt++;
        end
    endtask

    task automatic step_exp(input string nm, input logic [6:0] v);
        sb.push_back('{nm, v});
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    task automatic run_rel(input string nm, input int a, input int b, input logic [3:0] c);
        for (int r = a; r <= b; r++) step_exp(nm, {exp_run(r), c});
    endtask

    // Drop locked after relative edge d; RUN is left on the third edge
    task automatic lose(input string nm, input int d, input logic [3:0] cb, input logic [3:0] ca);
        locked = 1'b0;
        run_rel(nm, d + 1, d + 2, cb);
        step_exp(nm, {3'b000, ca});
        repeat (3) step_exp(nm, {3'b000, ca});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, want finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] cur, nxt;
        tbl = '{
            '{1'b1, 7'b000_0000}, '{1'b1, 7'b000_0000}, '{1'b1, 7'b000_0000}, '{1'b0, 7'b000_0000},
            '{1'b0, 7'b000_0000}, '{1'b0, 7'b000_0000}, '{1'b0, 7'b000_0000}, '{1'b0, 7'b000_0000},
            '{1'b1, 7'b000_0000}, '{1'b1, 7'b000_0000}, '{1'b1, 7'b000_0000}, '{1'b1, 7'b000_0000},
            '{1'b1, 7'b000_0000}, '{1'b1, 7'b000_0000}, '{1'b1, 7'b100_0000}, '{1'b1, 7'b100_0000}
        };
        #1;
        sb.push_back('{"reset_async", 7'b0});
        pop_cmp();
        @(posedge clk);
        #1;
        sb.push_back('{"reset_held", 7'b0});
        pop_cmp();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            locked = tbl[i].lk;
            step_exp($sformatf("tbl%0d", i), tbl[i].v);
        end
        run_rel("run1", 8, 110, 4'd0);
        lose("loss1", 110, 4'd0, 4'd1);
        locked = 1'b1;
        run_rel("relock", 0, 23, 4'd1);
        lose("loss_on_tick", 23, 4'd1, 4'd2);
        cur = 4'd2;
        for (int k = 0; k < 17; k++) begin
            nxt = (cur == 4'd15) ? cur : cur + 4'd1;
            locked = 1'b1;
            run_rel("sat_run", 0, 7, cur);
            lose("sat_loss", 7, cur, nxt);
            cur = nxt;
        end
        locked = 1'b1;
        run_rel("pre_async", 0, 16, 4'd15);
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{"async_mid_run", 7'b0});
        pop_cmp();
        @(posedge clk);
        #1;
        sb.push_back('{"async_held", 7'b0});
        pop_cmp();
        rst_n = 1'b1;
        run_rel("restart", 0, 26, 4'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
